// File: rtl/ni_inject.sv
// ni_inject: local network-interface injector feeding router local port 4.
// Core flits are staged in a small FIFO, a virtual channel is allocated per
// packet, and per-VC credits bound the number of flits in flight downstream.
// Build option: define NI_VC_RR_EN for round-robin VC allocation; when it is
// left undefined the lowest-index eligible VC wins.
module ni_inject #(
  parameter int DATAW      = 63,
  parameter int VCH        = 1,
  parameter int VCHW       = 0,
  parameter int BUFDEPTH   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [DATAW:0]   odata,
  output logic             ovalid,
  output logic [VCHW:0]    ovch,
  input  logic [VCH:0]     iack,
  input  logic [VCH:0]     ilck,
  output logic             proto_err,
  output logic             cred_err
);

  localparam int NVC = VCH + 1;
  localparam int CW  = $clog2(BUFDEPTH + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  // ---------------- staging FIFO ----------------
  logic [DATAW:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic           full, empty, push, pop;
  logic [DATAW:0] head_flit;
  logic [1:0]     head_type;

  assign full      = (fifo_cnt_q == FCW'(FIFO_DEPTH));
  assign empty     = (fifo_cnt_q == '0);
  assign src_ready = ~full;
  assign push      = src_valid & ~full;
  // The head is read combinationally so the pop decision and the registered
  // output happen in consecutive cycles (two-cycle core-to-router latency).
  assign head_flit = fifo_mem[rd_ptr_q];
  assign head_type = head_flit[DATAW:DATAW-1];

  // Payload storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= src_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------- per-VC credits ----------------
  logic [CW-1:0]  cred_q [NVC];
  logic [CW-1:0]  cred_d [NVC];
  logic [VCH:0]   send_v;
  logic [VCH:0]   ack_sat;
  logic [VCH:0]   elig;
  logic           send_en;
  logic [VCHW:0]  send_vc;

  genvar gi;
  generate
    for (gi = 0; gi < NVC; gi++) begin : g_vc
      assign send_v[gi]  = send_en && (send_vc == (VCHW+1)'(gi));
      assign ack_sat[gi] = iack[gi] && (cred_q[gi] == CW'(BUFDEPTH));
      assign elig[gi]    = (cred_q[gi] != '0) && !ilck[gi];
      // Send and return in the same cycle cancel; a return at full credit
      // saturates (and is flagged as an error).
      assign cred_d[gi]  = (iack[gi] == send_v[gi]) ? cred_q[gi] :
                           iack[gi] ? (ack_sat[gi] ? cred_q[gi] : cred_q[gi] + 1'b1) :
                                      cred_q[gi] - 1'b1;
    end
  endgenerate

  // ---------------- VC allocation ----------------
  logic          found;
  logic [VCHW:0] alloc_vc;

`ifdef NI_VC_RR_EN
  logic [VCHW:0] rr_q, rr_d;

  // Round-robin search starting at the rr pointer.
  always_comb begin
    int            idx;
    logic [VCHW:0] cand;
    idx      = 0;
    cand     = '0;
    found    = 1'b0;
    alloc_vc = '0;
    for (int i = 0; i < NVC; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NVC) idx = idx - NVC;
      cand = idx[VCHW:0];
      if (!found && elig[cand]) begin
        found    = 1'b1;
        alloc_vc = cand;
      end
    end
  end
`else
  // Fixed priority: scan downward so the lowest eligible index wins.
  always_comb begin
    logic [VCHW:0] cand;
    cand     = '0;
    found    = 1'b0;
    alloc_vc = '0;
    for (int i = NVC - 1; i >= 0; i--) begin
      cand = i[VCHW:0];
      if (elig[cand]) begin
        found    = 1'b1;
        alloc_vc = cand;
      end
    end
  end
`endif

  // ---------------- packet FSM ----------------
  logic [0:0]     state_q, state_d;
  logic [VCHW:0]  cur_vc_q, cur_vc_d;
  logic [DATAW:0] odata_q, odata_d;
  logic           ovalid_q, ovalid_d;
  logic [VCHW:0]  ovch_q, ovch_d;
  logic           proto_err_q, proto_err_d;
  logic           cred_err_q, cred_err_d;

  // Per-cycle pop/send decision and next output register values.
  always_comb begin
    state_d     = state_q;
    cur_vc_d    = cur_vc_q;
    odata_d     = odata_q;
    ovch_d      = ovch_q;
    ovalid_d    = 1'b0;
    proto_err_d = proto_err_q;
    cred_err_d  = cred_err_q | (|ack_sat);
    pop         = 1'b0;
    send_en     = 1'b0;
    send_vc     = cur_vc_q;
`ifdef NI_VC_RR_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head_type == T_HEAD || head_type == T_HT) begin
            if (found) begin
              pop      = 1'b1;
              send_en  = 1'b1;
              send_vc  = alloc_vc;
              odata_d  = head_flit;
              ovch_d   = alloc_vc;
              ovalid_d = 1'b1;
              if (head_type == T_HEAD) begin
                state_d  = ST_SEND;
                cur_vc_d = alloc_vc;
              end
`ifdef NI_VC_RR_EN
              rr_d = (alloc_vc == (VCHW+1)'(VCH)) ? '0 : alloc_vc + 1'b1;
`endif
            end
          end else begin
            // Stray body/tail with no open packet: drop it and flag.
            pop         = 1'b1;
            proto_err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        // The VC is owned for the whole packet, so ilck is not consulted.
        if (!empty && cred_q[cur_vc_q] != '0) begin
          pop      = 1'b1;
          send_en  = 1'b1;
          send_vc  = cur_vc_q;
          odata_d  = head_flit;
          ovch_d   = cur_vc_q;
          ovalid_d = 1'b1;
          if (head_type == T_TAIL) begin
            state_d = ST_IDLE;
          end else if (head_type != T_BODY) begin
            // A new head inside a packet closes the current one.
            proto_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset discarding all traffic.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q     <= ST_IDLE;
      cur_vc_q    <= '0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      ovch_q      <= '0;
      proto_err_q <= 1'b0;
      cred_err_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < NVC; i++) cred_q[i] <= CW'(BUFDEPTH);
`ifdef NI_VC_RR_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_vc_q    <= cur_vc_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      ovch_q      <= ovch_d;
      proto_err_q <= proto_err_d;
      cred_err_q  <= cred_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      for (int i = 0; i < NVC; i++) cred_q[i] <= cred_d[i];
`ifdef NI_VC_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign ovch      = ovch_q;
  assign proto_err = proto_err_q;
  assign cred_err  = cred_err_q;

endmodule

// File: tb/tb_ni_inject.sv
// Directed bench for ni_inject: table of per-cycle vectors plus hand-written
// sequences for reset, error flags, FIFO full and asynchronous reset.
module tb_ni_inject;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] T = 2'b10;
  localparam logic [1:0] X = 2'b11;
`ifdef NI_VC_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_;
  logic [63:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [63:0] odata;
  logic        ovalid;
  logic [0:0]  ovch;
  logic [1:0]  iack;
  logic [1:0]  ilck;
  logic        proto_err;
  logic        cred_err;

  always #5 clk = ~clk;

  ni_inject dut (
    .clk       (clk),
    .rst_      (rst_),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .odata     (odata),
    .ovalid    (ovalid),
    .ovch      (ovch),
    .iack      (iack),
    .ilck      (ilck),
    .proto_err (proto_err),
    .cred_err  (cred_err)
  );

  typedef struct {
    bit         rst;
    bit         sv;
    logic [1:0] ty;
    logic [7:0] pl;
    logic [1:0] ack;
    logic [1:0] lck;
    bit         eov;
    logic [1:0] ety;
    logic [7:0] epl;
    int         evc;
    int         ecr0;
    int         ecr1;
  } vec_t;

  vec_t tbl[$];
  int   npass = 0;
  int   ntot  = 0;

  function automatic logic [63:0] flit(input logic [1:0] ty, input logic [7:0] pl);
    return {ty, 54'd0, pl};
  endfunction

  task automatic row(input bit r, input bit sv, input logic [1:0] ty, input logic [7:0] pl,
                     input logic [1:0] ack, input logic [1:0] lck, input bit eov,
                     input logic [1:0] ety, input logic [7:0] epl, input int evc,
                     input int ecr0, input int ecr1);
    vec_t v;
    v.rst = r; v.sv = sv; v.ty = ty; v.pl = pl; v.ack = ack; v.lck = lck;
    v.eov = eov; v.ety = ety; v.epl = epl; v.evc = evc; v.ecr0 = ecr0; v.ecr1 = ecr1;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_      = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;
    iack      = '0;
    ilck      = '0;
    tick();
    tick();
    rst_ = 1'b0;
  endtask

  task automatic push(input logic [1:0] ty, input logic [7:0] pl);
    src_valid = 1'b1;
    src_data  = flit(ty, pl);
  endtask

  task automatic idle();
    src_valid = 1'b0;
    src_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rst sv ty pl  ack   lck   eov ety epl evc       ecr0           ecr1
    // 3-flit packet on VC 0, then credits returned one per cycle
    row(1, 1, H, 1,  2'b00, 2'b00, 0, B, 0,  0,        -1,            -1);
    row(0, 1, B, 2,  2'b00, 2'b00, 1, H, 1,  0,        -1,            -1);
    row(0, 1, T, 3,  2'b00, 2'b00, 1, B, 2,  0,        -1,            -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 1, T, 3,  0,        -1,            -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 0, B, 0,  0,        1,             -1);
    row(0, 0, B, 0,  2'b01, 2'b00, 0, B, 0,  0,        2,             -1);
    row(0, 0, B, 0,  2'b01, 2'b00, 0, B, 0,  0,        3,             -1);
    row(0, 0, B, 0,  2'b01, 2'b00, 0, B, 0,  0,        4,             -1);
    // 6-flit packet: stalls after 4 flits, each iack releases exactly one
    row(1, 1, H, 10, 2'b00, 2'b00, 0, B, 0,  0,        -1,            -1);
    row(0, 1, B, 11, 2'b00, 2'b00, 1, H, 10, 0,        3,             -1);
    row(0, 1, B, 12, 2'b00, 2'b00, 1, B, 11, 0,        -1,            -1);
    row(0, 1, B, 13, 2'b00, 2'b00, 1, B, 12, 0,        -1,            -1);
    row(0, 1, B, 14, 2'b00, 2'b00, 1, B, 13, 0,        0,             -1);
    row(0, 1, T, 15, 2'b00, 2'b00, 0, B, 0,  0,        0,             -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 0, B, 0,  0,        -1,            -1);
    row(0, 0, B, 0,  2'b01, 2'b00, 0, B, 0,  0,        1,             -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 1, B, 14, 0,        0,             -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 0, B, 0,  0,        -1,            -1);
    row(0, 0, B, 0,  2'b01, 2'b00, 0, B, 0,  0,        -1,            -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 1, T, 15, 0,        0,             -1);
    // VC 0 locked at allocation -> VC 1; lock on VC 1 mid-packet is ignored
    row(1, 1, H, 20, 2'b00, 2'b01, 0, B, 0,  0,        -1,            -1);
    row(0, 1, B, 21, 2'b00, 2'b01, 1, H, 20, 1,        -1,            -1);
    row(0, 1, T, 22, 2'b00, 2'b10, 1, B, 21, 1,        -1,            -1);
    row(0, 0, B, 0,  2'b00, 2'b10, 1, T, 22, 1,        4,             1);
    row(0, 0, B, 0,  2'b00, 2'b00, 0, B, 0,  0,        -1,            1);
    // two single-flit packets: VC choice depends on allocation policy
    row(1, 1, X, 30, 2'b00, 2'b00, 0, B, 0,  0,        -1,            -1);
    row(0, 1, X, 31, 2'b00, 2'b00, 1, X, 30, 0,        -1,            -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 1, X, 31, RR,       -1,            -1);
    row(0, 0, B, 0,  2'b00, 2'b00, 0, B, 0,  0,        (RR!=0)?3:2,   (RR!=0)?3:4);

    // ---- reset values ----
    do_reset();
    chk("rst_odata",     odata,            64'd0);
    chk("rst_ovalid",    64'(ovalid),      64'd0);
    chk("rst_ovch",      64'(ovch),        64'd0);
    chk("rst_proto_err", 64'(proto_err),   64'd0);
    chk("rst_cred_err",  64'(cred_err),    64'd0);
    chk("rst_src_ready", 64'(src_ready),   64'd1);
    chk("rst_cred0",     64'(dut.cred_q[0]), 64'd4);
    chk("rst_cred1",     64'(dut.cred_q[1]), 64'd4);

    // ---- table-driven vectors ----
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      src_valid = tbl[i].sv;
      src_data  = tbl[i].sv ? flit(tbl[i].ty, tbl[i].pl) : 64'd0;
      iack      = tbl[i].ack;
      ilck      = tbl[i].lck;
      tick();
      $display("vec %0d: ovalid=%0b ovch=%0d odata=%h", i, ovalid, ovch, odata);
      chk($sformatf("vec%0d_ovalid", i), 64'(ovalid), 64'(tbl[i].eov));
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d_odata", i), odata, flit(tbl[i].ety, tbl[i].epl));
        chk($sformatf("vec%0d_ovch", i), 64'(ovch), 64'(tbl[i].evc));
      end
      chk($sformatf("vec%0d_src_ready", i), 64'(src_ready), 64'd1);
      chk($sformatf("vec%0d_proto_err", i), 64'(proto_err), 64'd0);
      chk($sformatf("vec%0d_cred_err", i), 64'(cred_err), 64'd0);
      if (tbl[i].ecr0 >= 0) chk($sformatf("vec%0d_cred0", i), 64'(dut.cred_q[0]), 64'(tbl[i].ecr0));
      if (tbl[i].ecr1 >= 0) chk($sformatf("vec%0d_cred1", i), 64'(dut.cred_q[1]), 64'(tbl[i].ecr1));
    end
    idle(); iack = '0; ilck = '0;

    // ---- stray body flit while IDLE ----
    do_reset();
    push(B, 8'h05);
    tick();
    idle();
    chk("proto_pre", 64'(proto_err), 64'd0);
    tick();
    $display("proto: ovalid=%0b proto_err=%0b", ovalid, proto_err);
    chk("proto_set",    64'(proto_err), 64'd1);
    chk("proto_noval",  64'(ovalid),    64'd0);
    tick();
    chk("proto_sticky", 64'(proto_err), 64'd1);
    chk("proto_noval2", 64'(ovalid),    64'd0);
    chk("proto_empty",  64'(dut.fifo_cnt_q), 64'd0);
    do_reset();
    chk("proto_clear",  64'(proto_err), 64'd0);

    // ---- credit return at full credit ----
    iack = 2'b01;
    tick();
    iack = 2'b00;
    $display("cred_err: cred_err=%0b cred0=%0d", cred_err, dut.cred_q[0]);
    chk("cerr_set",   64'(cred_err),       64'd1);
    chk("cerr_cred0", 64'(dut.cred_q[0]),  64'd4);
    tick();
    chk("cerr_sticky", 64'(cred_err),      64'd1);

    // ---- send and iack on VC 0 in the same cycle at credit 2 ----
    do_reset();
    push(H, 8'd40); tick();
    push(B, 8'd41); tick();
    push(B, 8'd42); tick();
    chk("same_pre_cred0", 64'(dut.cred_q[0]), 64'd2);
    idle(); iack = 2'b01; tick();
    iack = 2'b00;
    $display("same-cycle: ovalid=%0b odata=%h cred0=%0d", ovalid, odata, dut.cred_q[0]);
    chk("same_ovalid", 64'(ovalid),         64'd1);
    chk("same_odata",  odata,               flit(B, 8'd42));
    chk("same_cred0",  64'(dut.cred_q[0]),  64'd2);

    // ---- FIFO fills while both VCs locked ----
    do_reset();
    ilck = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push(X, 8'(50 + k));
      tick();
      chk($sformatf("full_hold%0d", k), 64'(ovalid), 64'd0);
    end
    idle();
    $display("full: src_ready=%0b count=%0d", src_ready, dut.fifo_cnt_q);
    chk("full_ready", 64'(src_ready), 64'd0);
    ilck = 2'b00;
    tick();
    chk("drain_ovalid", 64'(ovalid),    64'd1);
    chk("drain_odata",  odata,          flit(X, 8'd50));
    chk("drain_ovch",   64'(ovch),      64'd0);
    chk("drain_ready",  64'(src_ready), 64'd1);
    tick();
    chk("drain2_odata", odata,          flit(X, 8'd51));
    chk("drain2_ovch",  64'(ovch),      64'(RR));

    // ---- asynchronous reset mid-packet ----
    do_reset();
    push(H, 8'd60); tick();
    push(B, 8'd61); tick();
    push(B, 8'd62); tick();
    chk("arst_pre_ovalid", 64'(ovalid), 64'd1);
    #2;
    idle();
    rst_ = 1'b1;
    #1;
    $display("async reset: ovalid=%0b cred0=%0d count=%0d", ovalid, dut.cred_q[0], dut.fifo_cnt_q);
    chk("arst_ovalid", 64'(ovalid),          64'd0);
    chk("arst_odata",  odata,                64'd0);
    chk("arst_cred0",  64'(dut.cred_q[0]),   64'd4);
    chk("arst_empty",  64'(dut.fifo_cnt_q),  64'd0);
    chk("arst_ready",  64'(src_ready),       64'd1);
    rst_ = 1'b0;
    tick();
    chk("arst_after1", 64'(ovalid), 64'd0);
    tick();
    chk("arst_after2", 64'(ovalid), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ni_inject.md
Name: ni_inject

Overview:
- Local network-interface injector that feeds router local port 4 (idata_4/ivalid_4/ivch_4, consuming oack_4/olck_4).
- Buffers flits from the core in a small FIFO and allocates a virtual channel per packet.
- Tracks per-VC credits returned by the router and emits at most one flit per cycle, never exceeding downstream buffer space.

Parameters:
- DATAW, 63: flit MSB index (flit is DATAW+1 bits); bits [DATAW:DATAW-1] are the flit type: 01 head, 00 body, 10 tail, 11 head+tail.
- VCH, 1: VC MSB index (VCH+1 virtual channels).
- VCHW, 0: VC-id MSB index.
- BUFDEPTH, 4: router input-VC buffer depth, i.e. initial credits per VC.
- FIFO_DEPTH, 4: core-side staging FIFO entries (power of two).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_  in  1  asynchronous reset, active-high (asserted = 1) despite the name.
- src_data  in  DATAW+1  flit from core.
- src_valid  in  1  core flit valid.
- src_ready  out  1  FIFO can accept; transfer when src_valid & src_ready.
- odata  out  DATAW+1  flit to router idata_4.
- ovalid  out  1  to router ivalid_4.
- ovch  out  VCHW+1  VC id to router ivch_4.
- iack  in  VCH+1  per-VC credit return (router oack_4), one credit per cycle high.
- ilck  in  VCH+1  per-VC locked (router olck_4); a locked VC must not be newly allocated.
- proto_err  out  1  sticky: non-head flit at FIFO head while IDLE.
- cred_err  out  1  sticky: iack while that VC's credit count is already BUFDEPTH.

Behaviour:
- Reset values: odata 0, ovalid 0, ovch 0, proto_err 0, cred_err 0, FIFO empty, all credits = BUFDEPTH, state IDLE, cur_vc 0, rr pointer 0. src_ready = !full, so it reads 1 once the FIFO is empty.
- Reset asserted mid-packet: everything returns to reset values immediately; FIFO contents and in-flight packets are discarded.
- FIFO: push on src_valid & src_ready. Simultaneous push and pop when full is not allowed, because src_ready is already 0.
- Credit counters: width $clog2(BUFDEPTH+1).
  - Decrement when a flit is sent on that VC.
  - Increment on iack[v].
  - Send and iack on the same VC in the same cycle: count unchanged.
  - iack at BUFDEPTH: count saturates and cred_err is set.
- FSM IDLE:
  - FIFO head type 01 or 11: pick an eligible VC (credit > 0 and ilck[v] = 0), pop, and register odata/ovch, ovalid = 1.
  - Head type 01: go to SEND with cur_vc = v.
  - Head type 11: stay in IDLE.
  - No eligible VC: hold, no pop, ovalid = 0.
  - Head type 00 or 10: pop and discard, set proto_err, ovalid = 0.
- FSM SEND:
  - If the FIFO is non-empty and credit[cur_vc] > 0: pop, drive on cur_vc, ovalid = 1. ilck is ignored in this state because the VC is owned.
  - Type 10 popped: go to IDLE.
  - Type 01 or 11 popped: set proto_err and treat as tail, go to IDLE.
  - Otherwise ovalid = 0 (bubble); odata holds its last value.
- Latency: flit accepted at cycle N appears with ovalid = 1 at N+2 when credit is available (FIFO write N, pop N+1, registered output N+2).
- Throughput: 1 flit/cycle while credits last.
- ovalid is a single-cycle qualifier; the router has no stall, and credits guarantee acceptance.

Optional Feature:
- Macro NI_VC_RR_EN.
- Defined: VC selection is round-robin. Search starts at rr pointer; after each head allocation, rr = allocated VC + 1, wrapping at VCH+1.
- Undefined: fixed priority, the lowest-index eligible VC wins; rr pointer is absent.

Test Plan:
- Reset, then a 3-flit packet (01,00,10) on 3 consecutive cycles, no iack → ovalid at cycles 2,3,4 on ovch 0; credit[0] = 1; src_ready stays 1.
- Packets of 6 flits with BUFDEPTH = 4 and no iack → 4 flits sent, then ovalid = 0. A single iack[0] pulse → exactly one more flit, 2 cycles later.
- ilck = 2'b01 at head allocation → packet goes on ovch 1. ilck[1] rising mid-packet → packet continues on VC 1 uninterrupted.
- Body flit (type 00) pushed while IDLE → discarded, proto_err = 1 from the next cycle until reset, no ovalid.
- iack[0] with credit[0] = 4 → cred_err = 1, credit stays 4. Send and iack on VC 0 in the same cycle at credit 2 → stays 2.
- NI_VC_RR_EN defined, two single-flit packets (type 11), both VCs free → ovch 0 then 1. Undefined → 0 then 0.
- rst_ pulsed high mid-packet → ovalid 0 within the same cycle (async), credits return to 4, FIFO empty.
